// File: rtl/mccpu_cntl.sv
// Multicycle MIPS-subset control sequencer.
// Steps each instruction through IF/ID/EXE/MEM/WB and drives the datapath
// enables and mux selects. Memory accesses in IF and MEM stall on mrdy.
//
//   state | meaning
//   SIF   | fetch: PC -> memory, PC+4 -> PC, write IR when memory is ready
//   SID   | decode: branch target -> ALU out reg; jumps complete here
//   SEXE  | execute: ALU op, branches resolve on z
//   SMEM  | memory access for lw/sw, waits for mrdy
//   SWB   | register file write-back
module mccpu_cntl (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mrdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    SIF  = 3'b000,
    SID  = 3'b001,
    SEXE = 3'b010,
    SMEM = 3'b011,
    SWB  = 3'b100
  } state_t;

  state_t state_q, state_n;

  logic rtype;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne;
  logic i_j, i_jal;
  logic legal, itype_wb, is_shift, is_branch, zimm;
  logic wpc_c, wir_c, wmem_c, wreg_c, illegal_c;
  logic [3:0] alu_fn;

  assign rtype  = (op == 6'b000000);
  assign i_add  = rtype & (func == 6'b100000);
  assign i_sub  = rtype & (func == 6'b100010);
  assign i_and  = rtype & (func == 6'b100100);
  assign i_or   = rtype & (func == 6'b100101);
  assign i_xor  = rtype & (func == 6'b100110);
  assign i_sll  = rtype & (func == 6'b000000);
  assign i_srl  = rtype & (func == 6'b000010);
  assign i_sra  = rtype & (func == 6'b000011);
  assign i_jr   = rtype & (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lui  = (op == 6'b001111);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                 i_addi | i_andi | i_ori | i_xori | i_lui | i_lw | i_sw | i_beq | i_bne |
                 i_j | i_jal;
  assign itype_wb  = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw;
  assign is_shift  = i_sll | i_srl | i_sra;
  assign is_branch = i_beq | i_bne;
  assign zimm      = i_andi | i_ori | i_xori;

  // ALU function for the EXE step, keyed by instruction
  always_comb begin
    alu_fn = 4'b0000;
    if (i_sub | is_branch)  alu_fn = 4'b0100;
    else if (i_and | i_andi) alu_fn = 4'b0001;
    else if (i_or  | i_ori)  alu_fn = 4'b0101;
    else if (i_xor | i_xori) alu_fn = 4'b0010;
    else if (i_lui)          alu_fn = 4'b0110;
    else if (i_sll)          alu_fn = 4'b0011;
    else if (i_srl)          alu_fn = 4'b0111;
    else if (i_sra)          alu_fn = 4'b1111;
  end

  // State register; clr wins over any in-flight access
  always_ff @(posedge clk) begin
    if (clr) state_q <= SIF;
    else     state_q <= state_n;
  end

  // Next state and datapath controls
  always_comb begin
    state_n   = SIF;
    wpc_c     = 1'b0;
    wir_c     = 1'b0;
    wmem_c    = 1'b0;
    wreg_c    = 1'b0;
    illegal_c = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    jal       = 1'b0;
    shift     = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    sext      = 1'b0;
    aluc      = 4'b0000;
    pcsource  = 2'b00;
    case (state_q)
      SIF: begin
        alusrcb = 2'b01;
        wpc_c   = mrdy;
        wir_c   = mrdy;
        state_n = mrdy ? SID : SIF;
      end
      SID: begin
        alusrcb = 2'b11;
        sext    = 1'b1;
        if (i_j) begin
          pcsource = 2'b11;
          wpc_c    = 1'b1;
        end else if (i_jal) begin
          pcsource = 2'b11;
          wpc_c    = 1'b1;
          wreg_c   = 1'b1;
          jal      = 1'b1;
        end else if (i_jr) begin
          pcsource = 2'b10;
          wpc_c    = 1'b1;
        end else if (!legal) begin
          illegal_c = 1'b1;
        end else begin
          state_n = SEXE;
        end
      end
      SEXE: begin
        alusrca = 1'b1;
        shift   = is_shift;
        alusrcb = (rtype | is_branch) ? 2'b00 : 2'b10;
        sext    = ~zimm;
        aluc    = alu_fn;
        if (is_branch) begin
          pcsource = 2'b01;
          wpc_c    = (i_beq & z) | (i_bne & ~z);
        end else if (i_lw | i_sw) begin
          state_n = SMEM;
        end else begin
          state_n = SWB;
        end
      end
      SMEM: begin
        iord   = 1'b1;
        wmem_c = i_sw;
        if (mrdy) state_n = i_lw ? SWB : SIF;
        else      state_n = SMEM;
      end
      SWB: begin
        wreg_c = 1'b1;
        m2reg  = i_lw;
        regrt  = itype_wb;
      end
      default: state_n = SIF;
    endcase
  end

  assign wpc     = wpc_c & ~clr;
  assign wir     = wir_c & ~clr;
  assign wmem    = wmem_c & ~clr;
  assign wreg    = wreg_c & ~clr;
  assign illegal = illegal_c & ~clr;
  assign state   = state_q;

endmodule

// File: tb/tb_mccpu_cntl.sv
// Bench for the multicycle control sequencer. The stimulus builds each
// instruction's expected cycle-by-cycle outputs from its latency and
// per-step control table and queues them; a monitor checks every cycle.
module tb_mccpu_cntl;

  logic clk = 1'b0;
  logic clr, z, mrdy;
  logic [5:0] op, func;
  logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca, sext, illegal;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;

  always #5 clk = ~clk;

  mccpu_cntl dut (
    .clk(clk), .clr(clr), .op(op), .func(func), .z(z), .mrdy(mrdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .jal(jal), .shift(shift), .alusrca(alusrca), .alusrcb(alusrcb),
    .sext(sext), .aluc(aluc), .pcsource(pcsource), .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca;
    logic [1:0] alusrcb;
    logic sext;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic illegal;
    logic [2:0] state;
  } out_t;

  out_t act;
  assign act = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, alusrca,
                alusrcb, sext, aluc, pcsource, illegal, state};

  out_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  localparam int K_ALU = 0, K_SH = 1, K_JR = 2, K_IS = 3, K_IZ = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

  logic [11:0] tbl [20] = '{
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
    {6'b000000, 6'b000010}, {6'b000000, 6'b000011}, {6'b000000, 6'b001000},
    {6'b001000, 6'b000000}, {6'b001100, 6'b000000}, {6'b001101, 6'b000000},
    {6'b001110, 6'b000000}, {6'b001111, 6'b000000}, {6'b100011, 6'b000000},
    {6'b101011, 6'b000000}, {6'b000100, 6'b000000}, {6'b000101, 6'b000000},
    {6'b000010, 6'b000000}, {6'b000011, 6'b000000}
  };

  // Instruction class and ALU code from the ISA table
  function automatic void classify(input logic [5:0] o, input logic [5:0] f,
                                   output int k, output logic [3:0] a);
    k = K_ILL;
    a = 4'b0000;
    case (o)
      6'b000000: case (f)
        6'b100000: begin k = K_ALU; a = 4'b0000; end
        6'b100010: begin k = K_ALU; a = 4'b0100; end
        6'b100100: begin k = K_ALU; a = 4'b0001; end
        6'b100101: begin k = K_ALU; a = 4'b0101; end
        6'b100110: begin k = K_ALU; a = 4'b0010; end
        6'b000000: begin k = K_SH;  a = 4'b0011; end
        6'b000010: begin k = K_SH;  a = 4'b0111; end
        6'b000011: begin k = K_SH;  a = 4'b1111; end
        6'b001000: k = K_JR;
        default:   k = K_ILL;
      endcase
      6'b001000: begin k = K_IS; a = 4'b0000; end
      6'b001100: begin k = K_IZ; a = 4'b0001; end
      6'b001101: begin k = K_IZ; a = 4'b0101; end
      6'b001110: begin k = K_IZ; a = 4'b0010; end
      6'b001111: begin k = K_IS; a = 4'b0110; end
      6'b100011: k = K_LW;
      6'b101011: k = K_SW;
      6'b000100: begin k = K_BEQ; a = 4'b0100; end
      6'b000101: begin k = K_BNE; a = 4'b0100; end
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      default:   k = K_ILL;
    endcase
  endfunction

  // Monitor: one expected output record per clock, compared mid-cycle
  always @(negedge clk) begin
    out_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d op=%b func=%b: actual %b required %b",
                 cyc, op, func, act, e);
      end
    end
  end

  task automatic step(input out_t e, input logic m, input logic zz, input logic c);
    clr  = c;
    mrdy = m;
    z    = zz;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zb,
                           input int sif, input int smem, input bit clr_mem);
    int k;
    logic [3:0] a;
    out_t e;
    classify(o, f, k, a);
    op = o;
    func = f;
    // fetch, with sif stall cycles first
    for (int i = 0; i < sif; i++) begin
      e = '0; e.alusrcb = 2'b01; e.state = 3'd0;
      step(e, 1'b0, rb(), 1'b0);
    end
    e = '0; e.alusrcb = 2'b01; e.state = 3'd0; e.wpc = 1'b1; e.wir = 1'b1;
    step(e, 1'b1, rb(), 1'b0);
    // decode
    e = '0; e.state = 3'd1; e.alusrcb = 2'b11; e.sext = 1'b1;
    if (k == K_J)   begin e.pcsource = 2'b11; e.wpc = 1'b1; end
    if (k == K_JAL) begin e.pcsource = 2'b11; e.wpc = 1'b1; e.wreg = 1'b1; e.jal = 1'b1; end
    if (k == K_JR)  begin e.pcsource = 2'b10; e.wpc = 1'b1; end
    if (k == K_ILL) e.illegal = 1'b1;
    step(e, rb(), rb(), 1'b0);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_ILL) return;
    // execute
    e = '0; e.state = 3'd2; e.alusrca = 1'b1; e.shift = (k == K_SH);
    e.alusrcb = (k == K_ALU || k == K_SH || k == K_BEQ || k == K_BNE) ? 2'b00 : 2'b10;
    e.sext = (k != K_IZ);
    e.aluc = a;
    if (k == K_BEQ || k == K_BNE) begin
      e.pcsource = 2'b01;
      e.wpc = (k == K_BEQ) ? zb : ~zb;
    end
    step(e, rb(), zb, 1'b0);
    if (k == K_BEQ || k == K_BNE) return;
    // memory
    if (k == K_LW || k == K_SW) begin
      e = '0; e.state = 3'd3; e.iord = 1'b1;
      if (clr_mem) begin
        step(e, 1'b0, rb(), 1'b1);
        return;
      end
      e.wmem = (k == K_SW);
      for (int i = 0; i < smem; i++) step(e, 1'b0, rb(), 1'b0);
      step(e, 1'b1, rb(), 1'b0);
      if (k == K_SW) return;
    end
    // write-back
    e = '0; e.state = 3'd4; e.wreg = 1'b1; e.m2reg = (k == K_LW);
    e.regrt = (k == K_IS || k == K_IZ || k == K_LW);
    step(e, rb(), rb(), 1'b0);
  endtask

  initial begin
    out_t e;
    int idx;
    logic [5:0] o, f;
    clr = 1'b1; mrdy = 1'b1; z = 1'b0; op = 6'b000000; func = 6'b100000;
    @(posedge clk);
    #1;
    // held in reset: SIF with write enables forced off
    e = '0; e.alusrcb = 2'b01; e.state = 3'd0;
    step(e, 1'b1, 1'b0, 1'b1);
    step(e, 1'b1, 1'b1, 1'b1);

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 0);  // add
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, 0);  // lw, 2 mem stalls
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 0);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 0);  // beq not taken
    run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, 0);  // bne taken
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, 0);  // jal
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, 0);  // jr
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1);  // sw aborted by clr
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 0);  // illegal
    run_instr(6'b000000, 6'b100000, 1'b0, 1, 0, 0);  // add after illegal
    run_instr(6'b000000, 6'b000011, 1'b0, 0, 0, 0);  // sra
    run_instr(6'b001101, 6'b000000, 1'b0, 0, 0, 0);  // ori
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 1, 0);  // sw with stalls

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        o = 6'($urandom_range(0, 63));
        f = 6'($urandom_range(0, 63));
      end else begin
        idx = $urandom_range(0, 19);
        {o, f} = tbl[idx];
        if (o != 6'b000000) f = 6'($urandom_range(0, 63));
      end
      run_instr(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d records left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mccpu_cntl.md
Name: mccpu_cntl

Overview:
- Control sequencer for the multicycle variant of the MIPS-subset CPU.
- Steps each instruction through the IF, ID, EXE, MEM and WB states and drives every datapath enable and mux select.
- Sits beside the multicycle datapath. It replaces the combinational control unit of the single-cycle core, which is unchanged.
- Waits on a memory-ready handshake so the shared instruction/data memory can have variable latency.

Parameters:
- none; instruction encoding and state encoding are fixed.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- op  in  6  ir[31:26], from the instruction register.
- func  in  6  ir[5:0].
- z  in  1  ALU zero flag, combinational in the current cycle.
- mrdy  in  1  memory done or ready for the current access.
- wpc  out  1  PC write enable.
- wir  out  1  instruction register write enable.
- wmem  out  1  memory write enable.
- wreg  out  1  register file write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU out register.
- regrt  out  1  destination select: 1 = rt, 0 = rd.
- m2reg  out  1  write-back data select: 1 = memory data register.
- jal  out  1  forces destination $31 and write data = PC.
- shift  out  1  ALU A select = shamt (overrides alusrca).
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- sext  out  1  1 = sign-extend imm, 0 = zero-extend.
- aluc  out  4  ALU op: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111.
- pcsource  out  2  00 = ALU result, 01 = ALU out register, 10 = register A (jr), 11 = jump target.
- illegal  out  1  one-cycle pulse on an undecoded instruction.
- state  out  3  current state, for debug.

Behaviour:
- States: SIF=000, SID=001, SEXE=010, SMEM=011, SWB=100. Encodings 101–111 go to SIF on the next edge with all enables 0.
- Decoded instructions:
  - R-type: add, sub, and, or, xor, sll, srl, sra, jr.
  - I-type: addi, andi, ori, xori, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Anything else is illegal.
- Outputs are combinational from the state, op, func, z and mrdy. Outputs not listed for a state are 0.
- Reset:
  - clr=1 at an edge sets the state to SIF regardless of the current state, including mid-MEM.
  - While clr=1, wpc, wir, wmem, wreg and illegal are forced to 0.
- SIF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - wpc=wir=mrdy.
  - Next state is SID if mrdy, else SIF (stall; PC and IR hold).
- SID:
  - alusrca=0, alusrcb=11, aluc=add, sext=1 (precomputes the branch target into the ALU out register).
  - j: pcsource=11, wpc=1, next SIF.
  - jal: pcsource=11, wpc=1, wreg=1, jal=1, next SIF.
  - jr: pcsource=10, wpc=1, next SIF.
  - illegal: illegal=1, no writes, next SIF.
  - All others: next SEXE.
- SEXE:
  - alusrca=1; shift=1 for sll/srl/sra.
  - alusrcb=00 for R-type, beq and bne; 10 otherwise.
  - aluc is set by the instruction: lw/sw use add, beq/bne use sub.
  - sext=0 for andi/ori/xori, 1 otherwise.
  - beq/bne: pcsource=01; wpc = (beq & z) | (bne & ~z); next SIF.
  - lw/sw: next SMEM.
  - All others: next SWB.
- SMEM:
  - iord=1; wmem=1 for sw, held high until mrdy.
  - mrdy=0: stay in SMEM.
  - mrdy=1: lw goes to SWB, sw goes to SIF.
- SWB:
  - wreg=1; m2reg=1 for lw; regrt=1 for I-type.
  - Next state SIF.
- Latency with mrdy held high:
  - j/jr/jal: 2 cycles.
  - beq/bne: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Each mrdy=0 cycle in SIF or SMEM adds 1 cycle.
- At most one of wpc, wmem, wreg is asserted per cycle, except jal (wpc and wreg together in SID).

Test Plan:
- add (op 000000, func 100000), mrdy=1 -> state sequence 0,1,2,4,0; aluc=0000 in SEXE; wreg=1, regrt=0, m2reg=0 in cycle 4.
- lw (op 100011), mrdy low for 2 cycles in SMEM -> 7 cycles total; iord=1 throughout SMEM; SWB has wreg=1, m2reg=1, regrt=1.
- beq (000100) with z=1 -> wpc=1, pcsource=01 in SEXE. Repeat with z=0 -> wpc=0. bne (000101), z=0 -> wpc=1. Each returns to SIF after 3 cycles.
- jal (000011) -> 2 cycles; in SID wpc=1, wreg=1, jal=1, pcsource=11. jr (000000/001000) -> pcsource=10.
- sw (101011) with clr pulsed in SMEM while mrdy=0 -> wmem=0 during clr; state=SIF next cycle; no wreg.
- op 111111 -> illegal=1 for exactly 1 cycle in SID; no write enables; back to SIF; next fetch proceeds normally.
